// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// State encoding and the slice width used by the time-shared adder.
package serial_add_ctrl_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_cla.sv
// 4-bit carry-lookahead slice, reused once per nibble by the controller.
// All carries come from generate/propagate terms, not a ripple chain.
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one cla_nibble is time-shared over NIBS cycles.
// Operands shift right each RUN cycle; result nibbles shift in from the top.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIBS  = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0]     sa;
  logic [WIDTH-1:0]     sb;
  logic [WIDTH-NIB-1:0] acc;
  logic [WIDTH-1:0]     full;
  logic                 cy;
  logic [CW-1:0]        k;
  logic                 last;
  logic [NIB-1:0]       ns;
  logic                 nco;
  logic                 load;

  cla_nibble u_cla (
    .a  (sa[NIB-1:0]),
    .b  (sb[NIB-1:0]),
    .ci (cy),
    .s  (ns),
    .co (nco)
  );

  assign last = (k == CW'(NIBS - 1));
  assign full = {ns, acc};
  assign load = (nxt == RUN) && (state != RUN);

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state == IDLE: nxt = start ? RUN : IDLE;
      state == RUN:  nxt = last ? DONE : RUN;
      state == DONE: nxt = start ? RUN : IDLE;
      default:       nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // acc keeps the finished low nibbles; full is the complete word on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      k    <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      sa <= a;
      sb <= b;
      cy <= cin;
      k  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> NIB;
      sb  <= sb >> NIB;
      cy  <= nco;
      acc <= full[WIDTH-1:NIB];
      k   <= last ? '0 : k + 1'b1;
      if (last) begin
        sum  <= full;
        cout <= nco;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a plain-arithmetic model.
// Directed scenarios first, then randomized traffic with input jitter.
module tb_serial_add_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;
  localparam int LIM = 4 * N + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one op and waits for done; leaves the bench in the DONE cycle.
  task automatic run_op(
    input  logic [W-1:0] ta,
    input  logic [W-1:0] tb2,
    input  logic         tc,
    input  bit           jit,
    output int           lat,
    output int           bn
  );
    logic [W-1:0] ps;
    logic         pc;
    a = ta;
    b = tb2;
    cin = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    ps = sum;
    pc = cout;
    lat = 0;
    bn = 0;
    while (done !== 1'b1 && lat < LIM) begin
      if (busy === 1'b1) bn++;
      checks++;
      if (sum !== ps || cout !== pc) begin
        errors++;
        $display("FAIL stable: sum=%h cout=%b required sum=%h cout=%b",
                 sum, cout, ps, pc);
      end
      if (jit) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        start = 1'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", LIM);
    end
  endtask

  task automatic check_op(
    input string        name,
    input logic [W-1:0] ta,
    input logic [W-1:0] tb2,
    input logic         tc,
    input int           lat,
    input int           bn
  );
    logic [W:0] e;
    e = model(ta, tb2, tc);
    checks++;
    if (sum !== e[W-1:0]) begin
      errors++;
      $display("FAIL %s sum: got %h required %h", name, sum, e[W-1:0]);
    end
    checks++;
    if (cout !== e[W]) begin
      errors++;
      $display("FAIL %s cout: got %b required %b", name, cout, e[W]);
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, N);
    end
    checks++;
    if (bn !== N) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, bn, N);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy at done: got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    a = 16'h1234;
    b = 16'h1111;
    tick();
    tick();
    checks++;
    if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b required all 0",
               busy, done, sum, cout);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_zero;
    int lat, bn;
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, lat, bn);
    check_op("zero", 16'h0000, 16'h0000, 1'b0, lat, bn);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_carry_chain;
    int lat, bn;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bn);
    check_op("carry", 16'hFFFF, 16'h0001, 1'b0, lat, bn);
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bn);
    check_op("b2b_first", 16'h1234, 16'h4321, 1'b1, lat, bn);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, bn);
    check_op("b2b_second", 16'h8000, 16'h8000, 1'b0, lat, bn);
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_ignore_start;
    logic [W:0] e;
    int n;
    int extra;
    e = model(16'h0F0F, 16'h1010, 1'b0);
    a = 16'h0F0F;
    b = 16'h1010;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
    checks++;
    if (n !== N) begin
      errors++;
      $display("FAIL ignore latency: got %0d required %0d", n, N);
    end
    checks++;
    if ({cout, sum} !== e) begin
      errors++;
      $display("FAIL ignore result: got %b_%h required %b_%h",
               cout, sum, e[W], e[W-1:0]);
    end
    extra = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore second op: got %0d active cycles required 0",
               extra);
    end
  endtask

  task automatic test_reset_midrun;
    int lat, bn;
    int seen;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat, bn);
    check_op("pre_rst", 16'h1111, 16'h2222, 1'b0, lat, bn);
    tick();
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
      errors++;
      $display("FAIL midrun_rst: busy=%b done=%b sum=%h cout=%b required 0",
               busy, done, sum, cout);
    end
    seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_quiet: got %0d active cycles required 0", seen);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bn);
    check_op("post_rst", 16'h00FF, 16'h0001, 1'b0, lat, bn);
    tick();
  endtask

  task automatic test_random;
    int lat, bn;
    logic [W-1:0] ta, tb2;
    logic tc;
    for (int i = 0; i < 40; i++) begin
      ta = W'($urandom);
      tb2 = W'($urandom);
      tc = 1'($urandom);
      if (i % 8 == 0) ta = '1;
      if (i % 8 == 1) tb2 = ~ta;
      run_op(ta, tb2, tc, 1'($urandom), lat, bn);
      check_op("random", ta, tb2, tc, lat, bn);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_zero();
    test_carry_chain();
    test_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
